// File: rtl/csr_timer_counters_if.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_counters_if
// Description : Data-bus bundle between the core and the timer peripheral.
// Revision    : 1.0 - initial release
// ============================================================================
interface csr_timer_counters_if;
    logic        iReadEnable;
    logic        iWriteEnable;
    logic [3:0]  iByteEnable;
    logic [31:0] iAddress;
    logic [31:0] iWriteData;
    logic [31:0] oReadData;

    modport master (
        output iReadEnable,
        output iWriteEnable,
        output iByteEnable,
        output iAddress,
        output iWriteData,
        input  oReadData
    );

    modport slave (
        input  iReadEnable,
        input  iWriteEnable,
        input  iByteEnable,
        input  iAddress,
        input  iWriteData,
        output oReadData
    );
endinterface
`default_nettype wire

// File: rtl/csr_timer_counters.sv
`default_nettype none
// ============================================================================
// Module      : csr_timer_counters
// Description : 64-bit cycle / millisecond time base with compare interrupt,
//               mapped on the 32-bit data bus with low-read snapshot of high.
// Revision    : 1.0 - initial release
// ============================================================================
module csr_timer_counters #(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter logic [31:0] BASE_ADDR   = 32'hFF20_0500
) (
    input  wire logic            iCLK,
    input  wire logic            iRST,
    csr_timer_counters_if.slave  bus,
    output logic [63:0]          core_clock_ticks,
    output logic [63:0]          miliseconds,
    output logic                 oTimerIRQ
);

    localparam int unsigned c_PRESC_PERIOD = CLK_FREQ_HZ / 1000;
    localparam int unsigned c_PRESC_W      = (c_PRESC_PERIOD > 1) ? $clog2(c_PRESC_PERIOD) : 1;
    localparam logic [c_PRESC_W-1:0] c_PRESC_TERM = c_PRESC_W'(c_PRESC_PERIOD - 1);

    localparam logic [2:0] c_IDX_TICKS_LO = 3'd0;
    localparam logic [2:0] c_IDX_TICKS_HI = 3'd1;
    localparam logic [2:0] c_IDX_MS_LO    = 3'd2;
    localparam logic [2:0] c_IDX_MS_HI    = 3'd3;
    localparam logic [2:0] c_IDX_CMP_LO   = 3'd4;
    localparam logic [2:0] c_IDX_CMP_HI   = 3'd5;
    localparam logic [2:0] c_IDX_CTRL     = 3'd6;

    logic [63:0]          r_ticks;
    logic [63:0]          r_ms;
    logic [c_PRESC_W-1:0] r_presc;
    logic [63:0]          r_cmp;
    logic                 r_count_en;
    logic                 r_irq_en;
    logic                 r_pending;
    logic                 r_irq;
    logic [31:0]          r_ticks_hi_sh;
    logic [31:0]          r_ms_hi_sh;
    logic [31:0]          r_rdata;

    logic                 w_hit;
    logic [2:0]           w_idx;
    logic                 w_rd;
    logic                 w_wr;
    logic                 w_presc_tc;
    logic                 w_cmp_hit;
    logic                 w_ctrl_wr;
    logic [31:0]          w_rdata;
    logic                 w_unused;

    assign w_hit      = (bus.iAddress[31:5] == BASE_ADDR[31:5]);
    assign w_idx      = bus.iAddress[4:2];
    assign w_rd       = bus.iReadEnable  & w_hit;
    assign w_wr       = bus.iWriteEnable & w_hit;
    assign w_presc_tc = (r_presc == c_PRESC_TERM);
    assign w_cmp_hit  = (r_ms >= r_cmp);
    assign w_ctrl_wr  = w_wr && (w_idx == c_IDX_CTRL) && bus.iByteEnable[0];
    assign w_unused   = ^bus.iAddress[1:0];

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] v;
        v = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) v[8*b +: 8] = new_v[8*b +: 8];
        end
        return v;
    endfunction

    // Time base: ticks, prescaler and ms all freeze together when disabled.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_ticks <= '0;
            r_ms    <= '0;
            r_presc <= '0;
        end else if (r_count_en) begin
            r_ticks <= r_ticks + 64'd1;
            if (w_presc_tc) begin
                r_presc <= '0;
                r_ms    <= r_ms + 64'd1;
            end else begin
                r_presc <= r_presc + c_PRESC_W'(1);
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cmp <= '1;
        end else if (w_wr) begin
            if (w_idx == c_IDX_CMP_LO)
                r_cmp[31:0]  <= f_merge(r_cmp[31:0],  bus.iWriteData, bus.iByteEnable);
            if (w_idx == c_IDX_CMP_HI)
                r_cmp[63:32] <= f_merge(r_cmp[63:32], bus.iWriteData, bus.iByteEnable);
        end
    end

    // A compare match wins over a simultaneous write-1-to-clear of pending.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_count_en <= 1'b1;
            r_irq_en   <= 1'b0;
            r_pending  <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_ctrl_wr) begin
                r_count_en <= bus.iWriteData[0];
                r_irq_en   <= bus.iWriteData[1];
            end
            if (w_cmp_hit)
                r_pending <= 1'b1;
            else if (w_ctrl_wr && bus.iWriteData[2])
                r_pending <= 1'b0;
            r_irq <= r_pending & r_irq_en;
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            c_IDX_TICKS_LO: w_rdata = r_ticks[31:0];
            c_IDX_TICKS_HI: w_rdata = r_ticks_hi_sh;
            c_IDX_MS_LO:    w_rdata = r_ms[31:0];
            c_IDX_MS_HI:    w_rdata = r_ms_hi_sh;
            c_IDX_CMP_LO:   w_rdata = r_cmp[31:0];
            c_IDX_CMP_HI:   w_rdata = r_cmp[63:32];
            c_IDX_CTRL:     w_rdata = {29'd0, r_pending, r_irq_en, r_count_en};
            default:        w_rdata = '0;
        endcase
    end

    // Low-word reads snapshot the high word from the same pre-increment value.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_rdata       <= '0;
            r_ticks_hi_sh <= '0;
            r_ms_hi_sh    <= '0;
        end else begin
            if (bus.iReadEnable)
                r_rdata <= w_hit ? w_rdata : 32'd0;
            if (w_rd && (w_idx == c_IDX_TICKS_LO))
                r_ticks_hi_sh <= r_ticks[63:32];
            if (w_rd && (w_idx == c_IDX_MS_LO))
                r_ms_hi_sh <= r_ms[63:32];
        end
    end

    assign bus.oReadData    = r_rdata;
    assign core_clock_ticks = r_ticks;
    assign miliseconds      = r_ms;
    assign oTimerIRQ        = r_irq;

endmodule
`default_nettype wire
